// File: rtl/user_record_ram.sv
// Per-user login record store (password, fail count, admin and lock flags) addressed by BCD user ID.
// After reset it sweeps every record to a known image, seeds one admin account, and then raises ready.
module user_record_ram #(
    parameter int          NUM_USERS  = 1000,
    parameter logic [11:0] ADMIN_ID   = 12'h001,
    parameter logic [15:0] ADMIN_PASS = 16'h1234
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        pass_rw,
    input  logic        count_rw,
    input  logic        admin_rw,
    input  logic        lock_rw,
    input  logic [11:0] addr,
    input  logic [15:0] pass_in,
    input  logic [3:0]  count_in,
    input  logic        admin_in,
    input  logic        lock_in,
    output logic [15:0] pass_out,
    output logic [3:0]  count_out,
    output logic        admin_out,
    output logic        lock_out,
    output logic        ready
);

    typedef enum logic {INIT, RUN} state_t;

    localparam int ADMIN_IDX = int'(ADMIN_ID[11:8]) * 100 + int'(ADMIN_ID[7:4]) * 10 + int'(ADMIN_ID[3:0]);

    // Record layout: {pass[21:6], count[5:2], admin[1], lock[0]}
    localparam logic [21:0] BLANK_REC = {16'h0000, 4'h0, 1'b0, 1'b1};
    localparam logic [21:0] ADMIN_REC = {ADMIN_PASS, 4'h0, 1'b1, 1'b0};

    state_t      state, state_next;
    logic [9:0]  cnt, cnt_next;

    logic [21:0] mem [NUM_USERS];

    logic [3:0]  d2, d1, d0;
    logic [9:0]  idx, idx_safe;
    logic        addr_valid;
    logic [21:0] stored, merged, wr_data;
    logic [9:0]  wr_addr;
    logic        wr_en, mem_we;

    assign d2 = addr[11:8];
    assign d1 = addr[7:4];
    assign d0 = addr[3:0];
    assign idx = 10'(d2) * 10'd100 + 10'(d1) * 10'd10 + 10'(d0);
    assign addr_valid = (d2 <= 4'd9) && (d1 <= 4'd9) && (d0 <= 4'd9) && (int'(idx) < NUM_USERS);
    assign idx_safe = addr_valid ? idx : 10'd0;

    // Per-field merge: unstrobed fields keep the stored value, strobed ones take new data
    assign stored = mem[idx_safe];
    assign merged = {pass_rw  ? pass_in  : stored[21:6],
                     count_rw ? count_in : stored[5:2],
                     admin_rw ? admin_in : stored[1],
                     lock_rw  ? lock_in  : stored[0]};

    assign wr_en   = (state == RUN) && cs && addr_valid && (pass_rw || count_rw || admin_rw || lock_rw);
    assign mem_we  = !rst && ((state == INIT) || wr_en);
    assign wr_addr = (state == INIT) ? cnt : idx_safe;
    assign wr_data = (state == INIT) ? ((int'(cnt) == ADMIN_IDX) ? ADMIN_REC : BLANK_REC) : merged;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port, write-first so a same-cycle write is visible on the next cycle
    always_ff @(posedge clk) begin
        if (rst || state == INIT || !addr_valid) begin
            {pass_out, count_out, admin_out, lock_out} <= BLANK_REC;
        end else if (wr_en) begin
            {pass_out, count_out, admin_out, lock_out} <= merged;
        end else begin
            {pass_out, count_out, admin_out, lock_out} <= stored;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            cnt   <= 10'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            INIT: begin
                cnt_next = cnt + 10'd1;
                if (int'(cnt) == NUM_USERS - 1) begin
                    state_next = RUN;
                    cnt_next   = cnt;
                end
            end
            RUN: begin
                state_next = RUN;
            end
            default: state_next = INIT;
        endcase
    end

    assign ready = (state == RUN);

endmodule

// File: tb/tb_user_record_ram.sv
// Scoreboard bench for user_record_ram: stimulus pushes expected records, a negedge monitor pops and compares.
module tb_user_record_ram;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs = 1'b0;
    logic        pass_rw = 1'b0, count_rw = 1'b0, admin_rw = 1'b0, lock_rw = 1'b0;
    logic [11:0] addr = 12'h000;
    logic [15:0] pass_in = 16'h0000;
    logic [3:0]  count_in = 4'h0;
    logic        admin_in = 1'b0, lock_in = 1'b0;
    logic [15:0] pass_out;
    logic [3:0]  count_out;
    logic        admin_out, lock_out, ready;

    typedef struct {
        logic [15:0] pass;
        logic [3:0]  count;
        logic        admin;
        logic        lock;
        string       name;
    } exp_t;

    exp_t expQ[$];
    int   total = 0;
    int   bad = 0;
    logic issue = 1'b0;
    logic issue_d = 1'b0;

    user_record_ram dut (
        .clk(clk), .rst(rst), .cs(cs),
        .pass_rw(pass_rw), .count_rw(count_rw), .admin_rw(admin_rw), .lock_rw(lock_rw),
        .addr(addr), .pass_in(pass_in), .count_in(count_in), .admin_in(admin_in), .lock_in(lock_in),
        .pass_out(pass_out), .count_out(count_out), .admin_out(admin_out), .lock_out(lock_out),
        .ready(ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) issue_d <= issue;

    function automatic exp_t mkExp(logic [15:0] p, logic [3:0] c, logic a, logic l, string n);
        exp_t e;
        e.pass = p; e.count = c; e.admin = a; e.lock = l; e.name = n;
        return e;
    endfunction

    task automatic checkOutput(exp_t e);
        total++;
        if (pass_out !== e.pass || count_out !== e.count || admin_out !== e.admin || lock_out !== e.lock) begin
            bad++;
            $display("[TB] FAIL %s: got pass=%h count=%h admin=%b lock=%b, want pass=%h count=%h admin=%b lock=%b",
                     e.name, pass_out, count_out, admin_out, lock_out, e.pass, e.count, e.admin, e.lock);
        end
    endtask

    task automatic checkFlag(string name, logic got, logic want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %b, want %b", name, got, want);
        end
    endtask

    // Monitor: one cycle after a request is issued, the registered outputs belong to it
    always @(negedge clk) begin
        if (issue_d) begin
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL scoreboard: got output with empty queue, want a queued expectation");
            end else begin
                checkOutput(expQ.pop_front());
            end
        end
    end

    task automatic applyStimulus(logic [11:0] a, logic c, logic prw, logic crw, logic arw, logic lrw,
                                 logic [15:0] pin, logic [3:0] cin, logic ain, logic lin, exp_t e);
        @(negedge clk);
        addr = a; cs = c;
        pass_rw = prw; count_rw = crw; admin_rw = arw; lock_rw = lrw;
        pass_in = pin; count_in = cin; admin_in = ain; lock_in = lin;
        issue = 1'b1;
        expQ.push_back(e);
    endtask

    task automatic readRec(logic [11:0] a, exp_t e);
        applyStimulus(a, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b0, e);
    endtask

    task automatic idle();
        @(negedge clk);
        cs = 1'b0; pass_rw = 1'b0; count_rw = 1'b0; admin_rw = 1'b0; lock_rw = 1'b0;
        issue = 1'b0;
    endtask

    // One-cycle reset then watch the sweep; abort_at >= 0 stops watching at that sweep cycle
    task automatic runSweep(int abort_at, bit do_reads);
        bit low_ok;
        @(negedge clk);
        cs = 1'b0; pass_rw = 1'b0; count_rw = 1'b0; admin_rw = 1'b0; lock_rw = 1'b0;
        rst = 1'b1;
        addr = 12'h001;
        issue = do_reads;
        if (do_reads) expQ.push_back(mkExp(16'h0000, 4'h0, 1'b0, 1'b1, "resetState"));
        @(negedge clk);
        rst = 1'b0;
        low_ok = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            if (ready !== 1'b0) low_ok = 1'b0;
            if (abort_at == k) begin
                issue = 1'b0;
                checkFlag("readyLowBeforeAbort", low_ok, 1'b1);
                return;
            end
            if (do_reads && (k < 4 || k >= 996)) begin
                addr = 12'h001;
                issue = 1'b1;
                expQ.push_back(mkExp(16'h0000, 4'h0, 1'b0, 1'b1, "adminDuringSweep"));
            end else begin
                issue = 1'b0;
            end
            @(negedge clk);
        end
        issue = 1'b0;
        checkFlag("readyLowDuringSweep", low_ok, 1'b1);
        checkFlag("readyAfterSweep", ready, 1'b1);
    endtask

    initial begin
        exp_t admin_img, blank_img, invalid_img;
        admin_img   = mkExp(16'h1234, 4'h0, 1'b1, 1'b0, "admin001");
        blank_img   = mkExp(16'h0000, 4'h0, 1'b0, 1'b1, "blankRecord");
        invalid_img = mkExp(16'h0000, 4'h0, 1'b0, 1'b1, "invalidAddr");

        repeat (2) @(negedge clk);
        runSweep(-1, 1'b1);

        readRec(12'h001, admin_img);
        readRec(12'h457, mkExp(16'h0000, 4'h0, 1'b0, 1'b1, "unused457"));

        applyStimulus(12'h042, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h9876, 4'h0, 1'b1, 1'b0,
                      mkExp(16'h9876, 4'h0, 1'b0, 1'b0, "write042"));
        readRec(12'h042, mkExp(16'h9876, 4'h0, 1'b0, 1'b0, "read042"));

        applyStimulus(12'h042, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFF, 4'h2, 1'b1, 1'b1,
                      mkExp(16'h9876, 4'h2, 1'b0, 1'b0, "countOnly042"));
        applyStimulus(12'h042, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFF, 4'h5, 1'b1, 1'b1,
                      mkExp(16'h9876, 4'h2, 1'b0, 1'b0, "csLowWrite042"));
        readRec(12'h042, mkExp(16'h9876, 4'h2, 1'b0, 1'b0, "after csLow042"));

        applyStimulus(12'h0A3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'hFFFF, 4'hF, 1'b1, 1'b0, invalid_img);
        applyStimulus(12'hF00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'hFFFF, 4'hF, 1'b1, 1'b0, invalid_img);
        readRec(12'h042, mkExp(16'h9876, 4'h2, 1'b0, 1'b0, "042 after invalid"));
        readRec(12'h001, admin_img);
        readRec(12'h103, blank_img);
        readRec(12'h000, blank_img);

        applyStimulus(12'h999, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h5555, 4'hF, 1'b1, 1'b0,
                      mkExp(16'h5555, 4'hF, 1'b1, 1'b0, "write999"));
        readRec(12'h998, mkExp(16'h0000, 4'h0, 1'b0, 1'b1, "neighbour998"));
        readRec(12'h999, mkExp(16'h5555, 4'hF, 1'b1, 1'b0, "read999"));
        idle();

        runSweep(500, 1'b0);
        runSweep(-1, 1'b0);
        readRec(12'h042, mkExp(16'h0000, 4'h0, 1'b0, 1'b1, "042 after abort reset"));
        applyStimulus(12'h042, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h4321, 4'h3, 1'b1, 1'b0,
                      mkExp(16'h4321, 4'h3, 1'b1, 1'b0, "rewrite042"));
        idle();
        runSweep(-1, 1'b0);
        readRec(12'h042, mkExp(16'h0000, 4'h0, 1'b0, 1'b1, "042 after run reset"));
        readRec(12'h001, mkExp(16'h1234, 4'h0, 1'b1, 1'b0, "admin after run reset"));
        readRec(12'h999, mkExp(16'h0000, 4'h0, 1'b0, 1'b1, "999 after run reset"));
        idle();
        idle();

        checkFlag("scoreboardDrained", expQ.size() == 0, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion by 200000, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
